muldiv_unit: RTL
================

# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers, added beside the ALU in the processor datapath for `mult`, `multu`, `div`, `divu`, `mfhi`, `mflo`, `mthi` and `mtlo`. It runs a shift-add multiply or a restoring divide on operand magnitudes, one bit per cycle. It then applies sign correction and writes HI/LO. While it works it asserts `busy`, which the control unit uses to stall the pipeline.

## Interface
- `WIDTH`, default 32: operand, HI and LO width. Legal range is 4..64.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
- `a`  in  WIDTH  multiplicand or dividend (rs).
- `b`  in  WIDTH  multiplier or divisor (rt).
- `wr_hi`  in  1  write `wdata` to HI (`mthi`).
- `wr_lo`  in  1  write `wdata` to LO (`mtlo`).
- `wdata`  in  WIDTH  data for `wr_hi`/`wr_lo`.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO are updated by an operation.
- `div_by_zero`  out  1  the last completed divide had `b==0`.
- `hi`  out  WIDTH  HI register; drives `mfhi`.
- `lo`  out  WIDTH  LO register; drives `mflo`.

## Operation
- State machine: IDLE, RUN, FIX.
- **IDLE**
  - On `start`: latch `op`, the magnitudes of `a` and `b` (signed ops only), the sign flags, and the original `a`.
  - Load iteration counter with `WIDTH` and go to RUN.
- **RUN**, one iteration per cycle, counter decrements, FIX when it reaches 0.
  - Multiply: 2·WIDTH-bit accumulator, LSB-first shift-add.
  - Divide: restoring divide producing a WIDTH-bit quotient and remainder.
- **FIX**, then IDLE with `done` pulsed.
  - Sign-correct the result and write HI/LO.
  - Multiply: negate the product if signs differ. HI = upper WIDTH bits, LO = lower WIDTH bits.
  - Divide: quotient truncates toward zero and goes to LO. Quotient is negated if signs differ; remainder takes the dividend's sign. Remainder goes to HI.
- Signed overflow, min / −1: falls out of the magnitude arithmetic as LO = min, HI = 0, flag clear.
- Divide by zero (`b==0`, either op):
  - LO = all ones, HI = original `a`, `div_by_zero` = 1.
  - The full latency is still taken.
- `div_by_zero` is updated only in FIX. It clears on any multiply, or on a divide with `b != 0`.
- `wr_hi`/`wr_lo`:
  - Honoured only in IDLE with `start` low; ignored while busy and ignored when `start` is high.
  - Both may be asserted together; both registers then take `wdata`.
- `start` while busy is ignored; it is neither queued nor allowed to corrupt state.
- Accumulator, counter and operand registers are internal; HI/LO change only in FIX or on `wr_hi`/`wr_lo`.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - State returns to IDLE.
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0.
  - An in-flight operation is discarded with no partial write.
- `start` sampled at edge E0:
  - `busy` is 1 from just after E0 until edge E0+WIDTH+1.
  - RUN occupies edges E0+1 .. E0+WIDTH; FIX is edge E0+WIDTH+1.
  - After E0+WIDTH+1: HI/LO hold the result, `done` = 1 for exactly one cycle, `busy` = 0.
- Latency is fixed at WIDTH+1 cycles from start to result for every op and operand value.
- Throughput: a `start` in the `done` cycle is accepted, giving back-to-back issue every WIDTH+2 edges.
- `mthi`/`mtlo` take effect at the edge where they are sampled; the new value is visible the following cycle.
- Outputs are registered. `busy` and `done` are state decodes with no combinational path from inputs.

## Test plan
- **Unsigned multiply, WIDTH=32:** multu 0xFFFFFFFF × 0xFFFFFFFF.
  - HI = 0xFFFFFFFE, LO = 0x00000001.
  - `busy` high for 33 cycles; `done` pulses one cycle after edge E0+33.
- **Signed multiply:**
  - WIDTH=32, mult −7 × 3: HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
  - WIDTH=8, mult 0x80 × 0x80: HI = 0x40, LO = 0x00.
- **Divide:**
  - divu 100 / 7: LO = 14, HI = 2.
  - div −7 / 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, `div_by_zero` = 0.
- **Divide by zero:**
  - divu 5 / 0: LO = 0xFFFFFFFF, HI = 5, `div_by_zero` = 1, same latency.
  - A following multu 2 × 3: flag clears, LO = 6.
- **Handshake and HI/LO writes:**
  - `start` and `mthi` 0x1234 pulsed mid-RUN: both ignored, result unchanged.
  - `mthi` 0x1234 in IDLE: `hi` = 0x1234 next cycle.
  - `start` in the `done` cycle: accepted.
  - `start` together with `wr_lo`: LO is written only by the operation.
- **Reset mid-operation:**
  - Assert `rst_n` low at RUN iteration 10: all outputs go to 0 immediately.
  - After release, multu 6 × 7 gives LO = 42, HI = 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide with HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mb_q, mb_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, done_q, done_d;

    logic               a_neg, b_neg, d_ge, dz;
    logic [WIDTH-1:0]   a_mag, b_mag, d_diff, q_fix, r_fix;
    logic [WIDTH:0]     m_sum, d_t;
    logic [2*WIDTH-1:0] prod, mul_next, div_next;

    // Datapath: operand magnitudes, one iteration step of each algorithm, sign fix-up
    always_comb begin
        a_neg    = op_i[0] & a_i[WIDTH-1];
        b_neg    = op_i[0] & b_i[WIDTH-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        m_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? mb_q : {WIDTH{1'b0}}};
        mul_next = {m_sum, acc_q[WIDTH-1:1]};
        d_t      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        d_ge     = d_t >= {1'b0, mb_q};
        d_diff   = d_t[WIDTH-1:0] - mb_q;
        div_next = {d_ge ? d_diff : d_t[WIDTH-1:0], acc_q[WIDTH-2:0], d_ge};
        prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;
        q_fix    = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        r_fix    = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        dz       = div_q && (mb_q == '0);
    end

    // Next-state and register updates for IDLE / RUN / FIX
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mb_d    = mb_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    div_d   = op_i[1];
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    mb_d    = b_mag;
                    a_d     = a_i;
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
                end else begin
                    hi_d = wr_hi_i ? wdata_i : hi_q;
                    lo_d = wr_lo_i ? wdata_i : lo_q;
                end
            end
            RUN: begin
                acc_d   = div_q ? div_next : mul_next;
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? FIX : RUN;
            end
            FIX: begin
                done_d  = 1'b1;
                dz_d    = dz;
                hi_d    = dz ? a_q : div_q ? r_fix : prod[2*WIDTH-1:WIDTH];
                lo_d    = dz ? {WIDTH{1'b1}} : div_q ? q_fix : prod[WIDTH-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mb_q    <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mb_q    <= mb_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy_o        = state_q != IDLE;
    assign done_o        = done_q;
    assign div_by_zero_o = dz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
endmodule
